// File: rtl/control_sequencer.sv
// Four-phase fetch/decode/execute/writeback controller for the 4-bit processor.
// Drives register-file addresses and ALU controls from a 16-bit instruction held in IR.
module control_sequencer #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [PC_W-1:0] instr_addr,
  input  logic [15:0]     instr_data,
  output logic [3:0]      Rd1,
  output logic [3:0]      Rd2,
  output logic [3:0]      Wr,
  output logic            RegWrite,
  input  logic [3:0]      Rd1_out,
  input  logic            overflow,
  output logic [2:0]      ALU_op,
  output logic            use_imm,
  output logic [3:0]      imm,
  output logic            ovf_flag,
  output logic            halted,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_BEQZ = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t          state_q, state_d;
  logic [15:0]     ir;
  logic [PC_W-1:0] pc, pc_d;
  logic            branch_taken;
  logic [2:0]      alu_op_d;
  logic            use_imm_d;
  logic            reg_write_d;
  logic [7:0]      target_full;
  logic [3:0]      op;

  assign op          = ir[15:12];
  assign target_full = {ir[11:8], ir[3:0]};

  // Register-file addresses come straight off IR flops, so they are stable from DECODE onward.
  assign Rd1        = ir[7:4];
  assign Rd2        = ir[3:0];
  assign Wr         = ir[11:8];
  assign imm        = ir[3:0];
  assign instr_addr = pc;
  assign state      = state_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = (op == OP_HALT) ? S_HALT : S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic: ALU controls are decoded from the ROM word as it enters IR,
  // so they are registered and valid in DECODE together with the addresses.
  always_comb begin
    alu_op_d    = 3'd0;
    use_imm_d   = 1'b0;
    reg_write_d = 1'b0;
    pc_d        = pc + PC_W'(1);
    case (instr_data[15:12])
      OP_ADD:  alu_op_d = 3'd0;
      OP_SUB:  alu_op_d = 3'd1;
      OP_AND:  alu_op_d = 3'd2;
      OP_OR:   alu_op_d = 3'd3;
      OP_XOR:  alu_op_d = 3'd4;
      OP_ADDI: begin alu_op_d = 3'd0; use_imm_d = 1'b1; end
      OP_LDI:  begin alu_op_d = 3'd5; use_imm_d = 1'b1; end
      default: alu_op_d = 3'd0;
    endcase
    if (state_q == S_EXEC && op >= OP_ADD && op <= OP_LDI)
      reg_write_d = 1'b1;
    if (op == OP_JMP || branch_taken)
      pc_d = target_full[PC_W-1:0];
    else if (op == OP_HALT)
      pc_d = pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir           <= 16'h0000;
      pc           <= '0;
      branch_taken <= 1'b0;
      RegWrite     <= 1'b0;
      ALU_op       <= 3'd0;
      use_imm      <= 1'b0;
      ovf_flag     <= 1'b0;
      halted       <= 1'b0;
    end else begin
      RegWrite <= reg_write_d;
      halted   <= (state_d == S_HALT);
      if (state_q == S_FETCH) begin
        ir      <= instr_data;
        ALU_op  <= alu_op_d;
        use_imm <= use_imm_d;
      end
      if (state_q == S_EXEC)
        branch_taken <= (op == OP_BEQZ) && (Rd1_out == 4'h0);
      if (state_q == S_WB) begin
        pc <= pc_d;
        // Sticky: only reset clears it.
        if (RegWrite && overflow) ovf_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: ROM model in the bench, hand-computed expectations.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  instr_addr;
  logic [15:0] instr_data;
  logic [3:0]  Rd1, Rd2, Wr;
  logic        RegWrite;
  logic [3:0]  Rd1_out = 4'h0;
  logic        overflow = 1'b0;
  logic [2:0]  ALU_op;
  logic        use_imm;
  logic [3:0]  imm;
  logic        ovf_flag;
  logic        halted;
  logic [2:0]  state;

  logic [15:0] rom [0:255];
  int checks = 0;
  int passed = 0;

  assign instr_data = rom[instr_addr];

  always #5 clk = ~clk;

  control_sequencer #(.PC_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .instr_addr(instr_addr), .instr_data(instr_data),
    .Rd1(Rd1), .Rd2(Rd2), .Wr(Wr), .RegWrite(RegWrite),
    .Rd1_out(Rd1_out), .overflow(overflow),
    .ALU_op(ALU_op), .use_imm(use_imm), .imm(imm),
    .ovf_flag(ovf_flag), .halted(halted), .state(state)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state !== 3'd0) $display("FAIL reset_state got %0d want 0", state); else passed++;
    checks++; if (instr_addr !== 8'h00) $display("FAIL reset_addr got %0h want 0", instr_addr); else passed++;
    checks++; if (RegWrite !== 1'b0) $display("FAIL reset_regwrite got %0b want 0", RegWrite); else passed++;
    checks++; if ({ALU_op, use_imm, ovf_flag, halted} !== 6'b0) $display("FAIL reset_ctrl got %b want 000000", {ALU_op, use_imm, ovf_flag, halted}); else passed++;
    checks++; if ({Rd1, Rd2, Wr, imm} !== 16'h0000) $display("FAIL reset_addrs got %h want 0000", {Rd1, Rd2, Wr, imm}); else passed++;
    step(3);
    checks++; if (state !== 3'd0) $display("FAIL idle_hold got %0d want 0", state); else passed++;
  endtask

  task automatic test_ldi();
    pulse_start();
    checks++; if (state !== 3'd1) $display("FAIL ldi_fetch got %0d want 1", state); else passed++;
    step(1);
    checks++; if (state !== 3'd2) $display("FAIL ldi_decode got %0d want 2", state); else passed++;
    checks++; if (ALU_op !== 3'd5 || use_imm !== 1'b1) $display("FAIL ldi_aluop got %0d/%0b want 5/1", ALU_op, use_imm); else passed++;
    checks++; if (imm !== 4'd5 || Wr !== 4'd1) $display("FAIL ldi_imm_wr got %0d/%0d want 5/1", imm, Wr); else passed++;
    step(2);
    checks++; if (state !== 3'd4 || RegWrite !== 1'b1) $display("FAIL ldi_wb got state %0d we %0b want 4/1", state, RegWrite); else passed++;
    step(1);
    checks++; if (RegWrite !== 1'b0) $display("FAIL ldi_we_pulse got %0b want 0", RegWrite); else passed++;
    checks++; if (instr_addr !== 8'h01) $display("FAIL ldi_next_addr got %0h want 01", instr_addr); else passed++;
  endtask

  task automatic test_add();
    step(1);
    checks++; if (Rd1 !== 4'd1 || Rd2 !== 4'd2) $display("FAIL add_rd got %0d/%0d want 1/2", Rd1, Rd2); else passed++;
    checks++; if (ALU_op !== 3'd0 || use_imm !== 1'b0) $display("FAIL add_aluop got %0d/%0b want 0/0", ALU_op, use_imm); else passed++;
    step(2);
    checks++; if (Wr !== 4'd3 || RegWrite !== 1'b1) $display("FAIL add_wb got %0d/%0b want 3/1", Wr, RegWrite); else passed++;
    step(1);
    checks++; if (ovf_flag !== 1'b0) $display("FAIL add_no_ovf got %0b want 0", ovf_flag); else passed++;
    checks++; if (instr_addr !== 8'h02) $display("FAIL add_next_addr got %0h want 02", instr_addr); else passed++;
  endtask

  task automatic test_overflow();
    step(3);
    overflow = 1'b1;
    checks++; if (RegWrite !== 1'b1) $display("FAIL ovf_we got %0b want 1", RegWrite); else passed++;
    step(1);
    overflow = 1'b0;
    checks++; if (ovf_flag !== 1'b1) $display("FAIL ovf_set got %0b want 1", ovf_flag); else passed++;
    step(3);
    checks++; if (state !== 3'd4 || RegWrite !== 1'b0) $display("FAIL nop_wb got %0d/%0b want 4/0", state, RegWrite); else passed++;
    step(5);
    checks++; if (ovf_flag !== 1'b1) $display("FAIL ovf_sticky got %0b want 1", ovf_flag); else passed++;
    checks++; if (instr_addr !== 8'h05) $display("FAIL nop_addr got %0h want 05", instr_addr); else passed++;
  endtask

  task automatic test_branch();
    rom[8'h00] = 16'h8243;
    rom[8'h23] = 16'h8243;
    rom[8'h24] = 16'h9F0F;
    rom[8'hFF] = 16'h0000;
    do_reset();
    checks++; if (ovf_flag !== 1'b0) $display("FAIL ovf_cleared got %0b want 0", ovf_flag); else passed++;
    Rd1_out = 4'h0;
    pulse_start();
    step(1);
    checks++; if (Rd1 !== 4'd4) $display("FAIL beqz_rd1 got %0d want 4", Rd1); else passed++;
    step(2);
    checks++; if (RegWrite !== 1'b0) $display("FAIL beqz_no_we got %0b want 0", RegWrite); else passed++;
    step(1);
    checks++; if (instr_addr !== 8'h23) $display("FAIL beqz_taken got %0h want 23", instr_addr); else passed++;
    Rd1_out = 4'h3;
    step(4);
    checks++; if (instr_addr !== 8'h24) $display("FAIL beqz_not_taken got %0h want 24", instr_addr); else passed++;
    step(4);
    checks++; if (instr_addr !== 8'hFF) $display("FAIL jmp_target got %0h want ff", instr_addr); else passed++;
    step(4);
    checks++; if (instr_addr !== 8'h00) $display("FAIL pc_wrap got %0h want 00", instr_addr); else passed++;
    Rd1_out = 4'h0;
  endtask

  task automatic test_halt();
    rom[8'h00] = 16'hF000;
    do_reset();
    pulse_start();
    step(4);
    checks++; if (state !== 3'd5 || halted !== 1'b1) $display("FAIL halt_state got %0d/%0b want 5/1", state, halted); else passed++;
    checks++; if (instr_addr !== 8'h00 || RegWrite !== 1'b0) $display("FAIL halt_pc got %0h/%0b want 00/0", instr_addr, RegWrite); else passed++;
    pulse_start();
    step(3);
    checks++; if (state !== 3'd5 || instr_addr !== 8'h00) $display("FAIL halt_hold got %0d/%0h want 5/00", state, instr_addr); else passed++;
  endtask

  task automatic test_reset_in_wb();
    rom[8'h00] = 16'h1312;
    do_reset();
    pulse_start();
    step(3);
    checks++; if (state !== 3'd4 || RegWrite !== 1'b1) $display("FAIL rwb_pre got %0d/%0b want 4/1", state, RegWrite); else passed++;
    rst = 1'b1;
    overflow = 1'b1;
    step(1);
    rst = 1'b0;
    overflow = 1'b0;
    checks++; if (RegWrite !== 1'b0 || state !== 3'd0) $display("FAIL rwb_post got %0b/%0d want 0/0", RegWrite, state); else passed++;
    checks++; if (instr_addr !== 8'h00 || ovf_flag !== 1'b0) $display("FAIL rwb_pc_ovf got %0h/%0b want 00/0", instr_addr, ovf_flag); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[0] = 16'h7105;
    rom[1] = 16'h1312;
    rom[2] = 16'h1312;
    step(1);
    test_reset();
    test_ldi();
    test_add();
    test_overflow();
    test_branch();
    test_halt();
    test_reset_in_wb();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
